// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, state encoding and PC
// helpers for the fetch unit slice.
package fetch_pkg;

  localparam int ILEN = 32;
  localparam logic [31:0] PC_LIMIT_DEF = 32'd60;
  localparam int unsigned TIMEOUT_DEF = 15;

  // fetch FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_HOLD  = 2'd2;
  localparam state_t S_DRAIN = 2'd3;

  function automatic logic [31:0] pc_wrap(
    input logic [31:0] pc,
    input logic [31:0] limit
  );
    return (pc > limit) ? 32'd0 : pc;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_incr.sv
// pc_incr: sequential +4 or word-aligned redirect,
// folded back to zero past the highest legal PC.
module pc_incr
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic [31:0] pc,
  input  logic [31:0] target,
  input  logic        sel_branch,
  output logic [31:0] pc_next
);

  logic [31:0] cand;
  logic        unused_lsb;

  // redirect targets are forced to word alignment
  assign unused_lsb = ^target[1:0];

  assign cand = sel_branch ? {target[31:2], 2'b00}
                           : pc + 32'd4;

  assign pc_next = pc_wrap(cand, PC_LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with
// redirect, drain of stale responses and request timeout.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pc_in,
  output logic [31:0]     pc_next,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [31:0]     instr_pc,
  input  logic            instr_ready,
  input  logic            branch_taken,
  input  logic [31:0]     branch_target,
  output logic            fetch_timeout
);

  localparam logic [3:0] TO = 4'(TIMEOUT);

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      cnt_q;
  logic [3:0]      cnt_d;
  logic [ILEN-1:0] instr_q;
  logic [31:0]     ipc_q;
  logic [31:0]     pc_calc;
  logic [31:0]     pc_d;
  logic            waiting;
  logic            expired;
  logic            ack_ok;
  logic            req_d;
  logic            cap;

  assign waiting = (state_q == S_FETCH)
                || (state_q == S_DRAIN);
  assign expired = waiting && (cnt_q == TO);
  // an ack landing in the retry gap is not trusted
  assign ack_ok  = imem_ack && !expired;

  pc_incr #(
    .PC_LIMIT(PC_LIMIT)
  ) u_pc_incr (
    .pc        (pc_in),
    .target    (branch_target),
    .sel_branch(branch_taken),
    .pc_next   (pc_calc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_in;
    req_d   = 1'b0;
    cap     = 1'b0;
    unique case (1'b1)
      state_q == S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      state_q == S_FETCH: begin
        req_d = !expired;
        if (branch_taken) begin
          pc_d    = pc_calc;
          cnt_d   = '0;
          state_d = (ack_ok || expired) ? S_FETCH
                                        : S_DRAIN;
        end else if (expired) begin
          cnt_d = '0;
        end else if (imem_ack) begin
          cap     = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      state_q == S_HOLD: begin
        if (branch_taken || instr_ready) begin
          pc_d    = pc_calc;
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      state_q == S_DRAIN: begin
        if (branch_taken) begin
          pc_d = pc_calc;
        end
        if (ack_ok || expired) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        instr_q <= imem_rdata;
        ipc_q   <= pc_in;
      end
    end
  end

  assign pc_next       = rst ? '0 : pc_d;
  assign imem_req      = !rst && req_d;
  assign imem_addr     = imem_req ? pc_in : '0;
  assign instr_valid   = !rst && (state_q == S_HOLD);
  assign instr         = rst ? '0 : instr_q;
  assign instr_pc      = rst ? '0 : ipc_q;
  assign fetch_timeout = !rst && expired;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random fetch traffic against a flag-level
// reference model, plus directed pinned scenarios.
module tb_fetch_unit;

  localparam logic [31:0] LIMIT = 32'd60;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        fetch_timeout;

  int checks = 0;
  int failures = 0;

  int lat = 2;
  bit silent = 0;
  bit mem_busy = 0;
  int mem_cnt = 0;
  bit ack_r = 0;
  bit s_req = 0;
  bit s_ack = 0;
  int p_ready = 100;
  int p_branch = 0;
  bit want_rst = 1;

  bit m_start = 0, m_held = 0, m_drain = 0;
  int m_wait = 0;
  logic [31:0] m_instr = '0, m_ipc = '0;
  bit n_start = 0, n_held = 0, n_drain = 0;
  int n_wait = 0;
  logic [31:0] n_instr = '0, n_ipc = '0, n_pc = '0;

  always #5 clk = ~clk;

  assign imem_ack = ack_r
    | (lat == 0 && !silent && !mem_busy && imem_req);

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .fetch_timeout(fetch_timeout)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic chkb(input string name,
                      input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] lim(input logic [31:0] x);
    return (x > LIMIT) ? 32'd0 : x;
  endfunction

  // reference model: held buffer, drain flag, wait count
  always @(negedge clk) begin : cmp
    bit fetching;
    bit waiting;
    bit to;
    bit acc;
    logic [31:0] e_pcn;
    if (rst) begin
      chk("rst_pc_next", pc_next, 32'd0);
      chkb("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 32'd0);
      chkb("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chkb("rst_timeout", fetch_timeout, 1'b0);
      n_start = 0;
      n_held = 0;
      n_drain = 0;
      n_wait = 0;
      n_instr = '0;
      n_ipc = '0;
      n_pc = '0;
    end else begin
      fetching = m_start && !m_held && !m_drain;
      waiting = m_start && !m_held;
      to = waiting && (m_wait == TMO);
      acc = imem_ack && !to;
      if (m_start && branch_taken)
        e_pcn = lim({branch_target[31:2], 2'b00});
      else if (m_held && instr_ready)
        e_pcn = lim(pc_in + 32'd4);
      else
        e_pcn = pc_in;
      chk("pc_next", pc_next, e_pcn);
      chkb("imem_req", imem_req, fetching && !to);
      if (fetching && !to)
        chk("imem_addr", imem_addr, pc_in);
      chkb("instr_valid", instr_valid, m_held);
      if (m_held) begin
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
      end
      chkb("fetch_timeout", fetch_timeout, to);
      n_start = 1;
      n_held = m_held;
      n_drain = m_drain;
      n_wait = m_wait;
      n_instr = m_instr;
      n_ipc = m_ipc;
      n_pc = e_pcn;
      if (!m_start) begin
        n_wait = 0;
      end else if (m_held) begin
        if (branch_taken || instr_ready) begin
          n_held = 0;
          n_wait = 0;
        end
      end else if (to) begin
        n_drain = 0;
        n_wait = 0;
      end else if (acc) begin
        if (fetching && !branch_taken) begin
          n_held = 1;
          n_instr = imem_rdata;
          n_ipc = pc_in;
        end
        n_drain = 0;
        n_wait = 0;
      end else if (branch_taken && fetching) begin
        n_drain = 1;
        n_wait = 0;
      end else begin
        n_wait = m_wait + 1;
      end
    end
    s_req = imem_req;
    s_ack = imem_ack;
  end

  task automatic step(input bit rnd, input bit br,
                      input logic [31:0] tgt,
                      input bit rdy);
    @(posedge clk);
    #1;
    m_start = n_start;
    m_held = n_held;
    m_drain = n_drain;
    m_wait = n_wait;
    m_instr = n_instr;
    m_ipc = n_ipc;
    pc_in = n_pc;
    ack_r = 0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        ack_r = 1;
        mem_busy = 0;
      end
    end else if (s_req && !s_ack && !silent && lat > 0) begin
      if (lat == 1) ack_r = 1;
      else begin
        mem_busy = 1;
        mem_cnt = lat - 1;
      end
    end
    if (rnd) begin
      rdy = int'($urandom_range(99)) < p_ready;
      br = int'($urandom_range(99)) < p_branch;
      if ($urandom_range(3) == 0) tgt = $urandom;
      else tgt = $urandom & 32'h7f;
      if (want_rst) want_rst = ($urandom_range(1) == 0);
      else want_rst = ($urandom_range(399) == 0);
    end
    rst = want_rst;
    instr_ready = rdy;
    branch_taken = br;
    branch_target = tgt;
    imem_rdata = $urandom;
    @(negedge clk);
  endtask

  initial begin : main
    int n;
    bit prev;
    bit seen;
    bit got;
    logic [31:0] d0;
    int pulses;
    int pidx;

    repeat (3) step(0, 0, 0, 0);
    chk("reset_pc_next", pc_next, 32'd0);
    chkb("reset_valid", instr_valid, 1'b0);
    chkb("reset_req", imem_req, 1'b0);
    want_rst = 0;

    // sequential fetch, ack two cycles after request
    n = 0;
    prev = 0;
    seen = 0;
    for (int c = 0; c < 200 && n < 17; c++) begin
      step(0, 0, 0, 1);
      if (imem_req && !prev) begin
        chk("seq_addr", imem_addr, 32'((n % 16) * 4));
        n++;
      end
      prev = imem_req;
      if (instr_valid && instr_pc == 32'd60) begin
        chk("wrap_pc_next", pc_next, 32'd0);
        seen = 1;
      end
    end
    chk("seq_count", 32'(n), 32'd17);
    chkb("wrap_seen", seen, 1'b1);

    // decode stalls for five cycles
    d0 = '0;
    for (int c = 0; c < 20 && !instr_valid; c++) begin
      step(0, 0, 0, 0);
      if (imem_ack) d0 = imem_rdata;
    end
    chkb("stall_hold", instr_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step(0, 0, 0, 0);
      chkb("stall_valid", instr_valid, 1'b1);
      chk("stall_instr", instr, d0);
      chk("stall_instr_pc", instr_pc, 32'd0);
      chk("stall_pc_next", pc_next, pc_in);
    end

    // redirect while a request is outstanding
    lat = 3;
    step(0, 0, 0, 1);
    step(0, 1, 32'h13, 1);
    chkb("br_req", imem_req, 1'b1);
    chk("br_addr", imem_addr, 32'd4);
    chk("br_pc_next", pc_next, 32'h10);
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      step(0, 0, 0, 1);
      chkb("drain_valid", instr_valid, 1'b0);
      if (imem_ack) got = 1;
      else chkb("drain_req", imem_req, 1'b0);
    end
    chkb("drain_ack_seen", got, 1'b1);
    step(0, 0, 0, 1);
    chkb("refetch_req", imem_req, 1'b1);
    chk("refetch_addr", imem_addr, 32'h10);
    chkb("refetch_valid", instr_valid, 1'b0);

    // branch beats accept in the same cycle
    lat = 1;
    for (int c = 0; c < 10 && !instr_valid; c++)
      step(0, 0, 0, 0);
    chkb("bw_hold", instr_valid, 1'b1);
    chk("bw_instr_pc", instr_pc, 32'h10);
    step(0, 1, 32'h40, 1);
    chk("bw_pc_next", pc_next, 32'd0);
    step(0, 0, 0, 0);
    chkb("bw_valid_drop", instr_valid, 1'b0);
    chkb("bw_req", imem_req, 1'b1);
    chk("bw_addr", imem_addr, 32'd0);

    // silent memory forces a timeout and retry
    for (int c = 0; c < 10 && !instr_valid; c++)
      step(0, 0, 0, 0);
    chkb("to_hold", instr_valid, 1'b1);
    silent = 1;
    step(0, 0, 0, 1);
    pulses = 0;
    pidx = -1;
    for (int k = 0; k < 17; k++) begin
      step(0, 0, 0, 0);
      if (fetch_timeout) begin
        pulses++;
        pidx = k;
        chkb("to_req_low", imem_req, 1'b0);
      end else begin
        chkb("to_req", imem_req, 1'b1);
        chk("to_addr", imem_addr, 32'd4);
      end
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_index", 32'(pidx), 32'd15);
    silent = 0;

    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0 && !mem_busy) begin
        lat = int'($urandom_range(3));
        silent = ($urandom_range(7) == 0);
        p_ready = int'($urandom_range(100));
        if ($urandom_range(3) == 0) p_branch = 0;
        else p_branch = int'($urandom_range(25));
      end
      step(1, 0, 0, 0);
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_LIMIT, default 60, highest legal byte PC; any computed PC above it wraps to 0.
REQ-002 SHALL have parameter TIMEOUT, default 15, max wait cycles for imem_ack before retry (4-bit counter).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pc_in  in  32  current PC from register file (PC_out).
REQ-006 pc_next  out  32  next PC, driven to register file PC_next every cycle.
REQ-007 imem_req  out  1  instruction memory read request.
REQ-008 imem_addr  out  32  byte address of request.
REQ-009 imem_ack  in  1  memory data valid, one-cycle pulse.
REQ-010 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-011 instr_valid  out  1  instr holds a fetched instruction.
REQ-012 instr  out  32  fetched instruction to decode.
REQ-013 instr_pc  out  32  byte address instr was fetched from.
REQ-014 instr_ready  in  1  decode accepts instr this cycle.
REQ-015 branch_taken  in  1  one-cycle redirect request.
REQ-016 branch_target  in  32  redirect byte address.
REQ-017 fetch_timeout  out  1  one-cycle pulse when a request exceeds TIMEOUT cycles.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, HOLD, DRAIN.
REQ-019 IDLE: outputs quiescent, pc_next = pc_in; unconditional move to FETCH next cycle.
REQ-020 FETCH: imem_req=1, imem_addr=pc_in, pc_next=pc_in; on imem_ack capture imem_rdata into instr, pc_in into instr_pc, move to HOLD; zero-wait ack (same cycle as first imem_req) SHALL be accepted.
REQ-021 HOLD: instr_valid=1, imem_req=0; instr/instr_pc stable until accepted.
REQ-022 HOLD with instr_ready=1: pc_next = pc_in+4 (0 if result > PC_LIMIT), instr_valid falls next cycle, move to FETCH; one instruction per 2 cycles minimum throughput.
REQ-023 HOLD with instr_ready=0: pc_next = pc_in, no state change.
REQ-024 branch_taken in any non-IDLE state: pc_next = {branch_target[31:2],2'b00}, or 0 if that exceeds PC_LIMIT; instr_valid cleared next cycle.
REQ-025 branch_taken in FETCH without imem_ack same cycle: move to DRAIN; with imem_ack same cycle: data discarded, move to FETCH.
REQ-026 branch_taken in HOLD: held instruction discarded even if instr_ready=1 same cycle (branch wins, no +4), move to FETCH.
REQ-027 DRAIN: imem_req=0, pc_next=pc_in; wait for the outstanding imem_ack, discard its data, then move to FETCH.
REQ-028 Wait counter SHALL clear on entry to FETCH/DRAIN and increment each cycle without imem_ack; reaching TIMEOUT SHALL pulse fetch_timeout, drop imem_req for one cycle, clear counter; FETCH re-issues at the same pc_in, DRAIN returns to FETCH.
REQ-029 All PC arithmetic 32-bit unsigned; carries beyond bit 31 discarded before PC_LIMIT compare.

Reset
REQ-030 While rst=1: state IDLE, pc_next=0, imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, fetch_timeout=0, wait counter 0.
REQ-031 rst mid-request SHALL abandon the request; a late imem_ack after reset release SHALL be ignored unless in FETCH.

Structure
REQ-032 FSM state enum, PC_LIMIT default and instruction width constant SHALL live in shared package fetch_pkg.
REQ-033 PC increment/wrap/align logic SHALL be sub-module pc_incr (inputs pc, target, sel_branch; output pc_next).

Verification
REQ-034 Reset, memory acks 2 cycles after each req, instr_ready=1 -> fetch addresses 0,4,8,...,60,0; instr_pc matches imem_addr.
REQ-035 pc_in=60 in HOLD, instr_ready=1 -> pc_next=0.
REQ-036 instr_ready held 0 for 5 cycles in HOLD -> instr_valid=1, instr unchanged, pc_next=pc_in all 5 cycles.
REQ-037 branch_taken, target=0x13 during FETCH with no ack -> DRAIN, next ack data discarded, next request at 0x10.
REQ-038 branch_taken and instr_ready same cycle in HOLD, target=0x40 -> pc_next=0, no instruction accepted twice.
REQ-039 No imem_ack for 16 cycles -> fetch_timeout pulses once at cycle 15, imem_req low one cycle, request re-issued at same address.
